// File: rtl/spi_pkg.sv
// Shared defaults and FSM encoding for the SPI receive framer and its FIFO.
package spi_pkg;

  localparam int LARGO_DEF = 8;
  localparam int DEPTH_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

endpackage

// File: rtl/spi_rx_fifo.sv
// First-word-fall-through receive FIFO: storage, wrapping pointers and fill level.
module spi_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     ready_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full, pop, wr_en;

  // A pop frees the head slot at the same edge, so a full FIFO still accepts a word then.
  always_comb begin
    full     = (level_q == LW'(DEPTH));
    pop      = valid_o && ready_i;
    wr_en    = push_i && (!full || pop);
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(wr_en) - LW'(pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

  // Masking the head with valid keeps rd_data at zero whenever the FIFO is empty.
  assign valid_o = (level_q != '0);
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign level_o = level_q;
  assign drop_o  = push_i && full && !pop;

endmodule

// File: rtl/spi_rx_framer.sv
// SPI receive framer: counts SIPO strobes per cs frame and queues complete words.
// Optional sticky overrun flag enabled by defining SPI_RX_OVERRUN_EN.
module spi_rx_framer
  import spi_pkg::*;
#(
  parameter int LARGO = LARGO_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cs,
  input  logic                     ena,
  input  logic [LARGO-1:0]         DatIn,
  input  logic                     rd_ready,
  input  logic                     ovr_clr,
  output logic                     rd_valid,
  output logic [LARGO-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     frame_err,
  output logic                     overrun
);

  localparam int BW = (LARGO > 1) ? $clog2(LARGO) : 1;
  localparam logic [BW-1:0] LAST = BW'(LARGO - 1);

  state_e        state_q;
  logic [BW-1:0] bit_cnt_q;
  logic          frame_err_q;
  logic          word_done;
  logic          drop;

  // The SIPO already holds the full word at the final strobe, whatever cs does.
  assign word_done = (state_q == RECV) && ena && (bit_cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cs) begin
            state_q   <= RECV;
            bit_cnt_q <= '0;
          end
        end
        RECV: begin
          if (!cs) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            frame_err_q <= (bit_cnt_q != '0) && !word_done;
          end else if (ena) begin
            bit_cnt_q <= word_done ? '0 : bit_cnt_q + BW'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          bit_cnt_q <= '0;
        end
      endcase
    end
  end

  spi_rx_fifo #(
    .WIDTH (LARGO),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (word_done),
    .data_i  (DatIn),
    .ready_i (rd_ready),
    .valid_o (rd_valid),
    .data_o  (rd_data),
    .level_o (level),
    .drop_o  (drop)
  );

  assign frame_err = frame_err_q;

`ifdef SPI_RX_OVERRUN_EN
  logic overrun_q;

  // Set wins over clear so a drop coinciding with ovr_clr is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overrun_q <= 1'b0;
    else if (drop)    overrun_q <= 1'b1;
    else if (ovr_clr) overrun_q <= 1'b0;
  end

  assign overrun = overrun_q;
`else
  logic unused_ovr;
  assign unused_ovr = &{1'b0, ovr_clr, drop};
  assign overrun    = 1'b0;
`endif

endmodule

// File: doc/spi_rx_framer.md
SPI_RX_FRAMER -- requirements
Module: spi_rx_framer

Interface
REQ-001 The block SHALL have parameter LARGO, default 8: word width in bits, which SHALL match the upstream SIPO shifter width.
REQ-002 The block SHALL have parameter DEPTH, default 4: receive FIFO depth in words; it SHALL be a power of 2 and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all block state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port cs, input, 1 bit: frame active, active-high, synchronous to clk.
REQ-006 The block SHALL have port ena, input, 1 bit: one-cycle strobe; it is the same strobe that shifts one bit into the upstream SIPO.
REQ-007 The block SHALL have port DatIn, input, LARGO bits: the parallel word from the SIPO, with bit 0 being the newest bit.
REQ-008 The block SHALL have port rd_ready, input, 1 bit: the consumer accepts the head word.
REQ-009 The block SHALL have port ovr_clr, input, 1 bit: clears the overrun flag.
REQ-010 The block SHALL have port rd_valid, output, 1 bit: the FIFO is non-empty.
REQ-011 The block SHALL have port rd_data, output, LARGO bits: the head word of the FIFO.
REQ-012 The block SHALL have port level, output, clog2(DEPTH)+1 bits: the FIFO fill count.
REQ-013 The block SHALL have port frame_err, output, 1 bit: a one-cycle pulse on a truncated frame.
REQ-014 The block SHALL have port overrun, output, 1 bit: a sticky flag for a dropped word.

Function
REQ-015 The FSM SHALL have two states, IDLE and RECV, plus a bit counter bit_cnt of clog2(LARGO) bits.
REQ-016 In IDLE with cs=1, the FSM SHALL go to RECV with bit_cnt=0; ena SHALL be ignored while in IDLE.
REQ-017 In RECV with ena=1 and bit_cnt<LARGO-1, bit_cnt SHALL increment.
REQ-018 In RECV with ena=1 and bit_cnt=LARGO-1, the block SHALL push DatIn into the FIFO at that edge and reset bit_cnt to 0. The SIPO shifts on the falling edge, so DatIn already holds the complete word at this edge.
REQ-019 In RECV with cs=0, the FSM SHALL go to IDLE and clear bit_cnt to 0. If bit_cnt is not 0 and no word completes at that edge, the block SHALL pulse frame_err for exactly one cycle and discard the partial word.
REQ-020 If cs falls in the same cycle as the final ena, the word SHALL be pushed and frame_err SHALL NOT pulse.
REQ-021 The FIFO SHALL be first-word-fall-through: rd_valid=(level!=0) and rd_data=head. A pushed word SHALL appear on rd_valid/rd_data in the cycle after its push edge.
REQ-022 A pop SHALL occur when rd_valid && rd_ready. While rd_valid=1, rd_data SHALL remain stable until it is popped.
REQ-023 For a push and a pop in the same cycle, both SHALL take effect and level SHALL be unchanged; this includes the full case.
REQ-024 A push when full with no pop SHALL drop the new word and leave the FIFO contents and level unchanged.
REQ-025 The read and write pointers SHALL wrap modulo DEPTH, and level SHALL saturate at neither end beyond 0..DEPTH.

Reset
REQ-026 Asserting rst SHALL immediately force: state=IDLE, bit_cnt=0, pointers=0, level=0, rd_valid=0, rd_data=0, frame_err=0, overrun=0.
REQ-027 A reset mid-frame or with the FIFO non-empty SHALL discard all words and SHALL NOT pulse frame_err.
REQ-028 After rst deasserts, a cs that is already high SHALL start a new frame at the first rising edge.

Configuration
REQ-029 Macro SPI_RX_OVERRUN_EN defined: overrun SHALL set at the edge where a word is dropped (per REQ-024), stay set until ovr_clr=1, and give set priority over a clear in the same cycle.
REQ-030 Macro SPI_RX_OVERRUN_EN undefined: overrun SHALL be constant 0 and ovr_clr SHALL be ignored; dropping behaviour SHALL be unchanged.

Structure
REQ-031 Shared package spi_pkg SHALL hold the LARGO and DEPTH defaults and the FSM state encoding (IDLE=0, RECV=1).
REQ-032 The FIFO SHALL be a sub-module named spi_rx_fifo (storage, pointers, level, push/pop), instantiated once; the FSM and bit counter SHALL stay in spi_rx_framer.

Verification
REQ-033 Frame capture: cs=1, 8 ena strobes with DatIn=8'hA5 at the 8th strobe -> rd_valid=1 and rd_data=8'hA5 one cycle later, level=1.
REQ-034 Truncation: cs=1, 5 ena strobes, then cs=0 -> one-cycle frame_err, level=0; the next full frame of 8'h3C -> rd_data=8'h3C.
REQ-035 Overflow: 5 words 8'h01..8'h05 pushed with rd_ready=0 -> level=4, words 8'h01..8'h04 read back in order, 8'h05 lost, overrun=1 (macro defined) or 0 (undefined); ovr_clr pulse -> overrun=0.
REQ-036 Full with simultaneous push and pop: FIFO full, rd_ready=1 during the 8'hFF push -> level stays 4 and 8'hFF is read last.
REQ-037 cs falls with the final ena -> word pushed, no frame_err.
REQ-038 rst asserted after 3 bits with 2 words queued -> all outputs 0 immediately, no frame_err; the next frame is captured normally.
